// File: rtl/alu_defs_pkg.sv
// ALU function codes and MIPS-32 opcode/funct constants shared by decode and ALU.
package alu_defs_pkg;

  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_ADDU = 4'hA;
  localparam logic [3:0] ALU_SUBU = 4'hB;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Widen a 16-bit immediate, sign- or zero-extended.
  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sign);
    return sign ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// $0 is hardwired to zero; writes to it are dropped.
module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] mem_q [32];

  // Write port; reset clears every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports, with $0 forced to zero.
  always_comb begin
    rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : mem_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : mem_q[raddr_b_i];
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS-32 decode stage: decodes one instruction per cycle, reads operands
// (with write-back bypass) and registers them for the ALU on the next negedge.
module decode_stage
  import alu_defs_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  input  logic               stall,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic [31:0]        wb_data,
  output logic signed [31:0] rs,
  output logic [31:0]        rs_unsigned,
  output logic signed [31:0] rt,
  output logic [31:0]        rt_unsigned,
  output logic [3:0]         ALUOp,
  output logic [4:0]         shamt,
  output logic [4:0]         dest,
  output logic               ex_valid,
  output logic               illegal,
  output logic [7:0]         illegal_count
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs_idx, rt_idx, rd_idx;
  logic [31:0] rs_rd, rt_rd, rs_fwd, rt_fwd, rt_sel;

  logic        legal, use_imm, sext_imm;
  logic [3:0]  alu_dec;
  logic [4:0]  dest_dec, shamt_dec;

  logic [31:0] rs_q, rs_d, rt_q, rt_d;
  logic [3:0]  alu_q, alu_d;
  logic [4:0]  shamt_q, shamt_d, dest_q, dest_d;
  logic        ex_valid_q, ex_valid_d, illegal_q, illegal_d;
  logic [7:0]  cnt_q, cnt_d;

  assign opcode = instr[31:26];
  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];
  assign rd_idx = instr[15:11];
  assign funct  = instr[5:0];

  mips_regfile u_regfile (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs_idx),
    .rdata_a_o (rs_rd),
    .raddr_b_i (rt_idx),
    .rdata_b_o (rt_rd)
  );

  // Instruction decode into ALU function, destination and immediate handling.
  always_comb begin
    legal     = 1'b1;
    use_imm   = 1'b0;
    sext_imm  = 1'b0;
    alu_dec   = ALU_NONE;
    dest_dec  = rt_idx;
    shamt_dec = 5'd0;
    case (opcode)
      OP_RTYPE: begin
        dest_dec = rd_idx;
        case (funct)
          FN_ADD:  alu_dec = ALU_ADD;
          FN_ADDU: alu_dec = ALU_ADDU;
          FN_SUB:  alu_dec = ALU_SUB;
          FN_SUBU: alu_dec = ALU_SUBU;
          FN_AND:  alu_dec = ALU_AND;
          FN_OR:   alu_dec = ALU_OR;
          FN_NOR:  alu_dec = ALU_NOR;
          FN_SLT:  alu_dec = ALU_SLT;
          FN_SLL:  begin alu_dec = ALU_SLL; shamt_dec = instr[10:6]; end
          FN_SRL:  begin alu_dec = ALU_SRL; shamt_dec = instr[10:6]; end
          FN_SRA:  begin alu_dec = ALU_SRA; shamt_dec = instr[10:6]; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI:  begin alu_dec = ALU_ADD;  use_imm = 1'b1; sext_imm = 1'b1; end
      OP_ADDIU: begin alu_dec = ALU_ADDU; use_imm = 1'b1; sext_imm = 1'b1; end
      OP_SLTI:  begin alu_dec = ALU_SLT;  use_imm = 1'b1; sext_imm = 1'b1; end
      OP_ANDI:  begin alu_dec = ALU_AND;  use_imm = 1'b1; end
      OP_ORI:   begin alu_dec = ALU_OR;   use_imm = 1'b1; end
      default:  legal = 1'b0;
    endcase
    if (!legal) begin
      alu_dec   = ALU_NONE;
      dest_dec  = 5'd0;
      shamt_dec = 5'd0;
    end
  end

  // Same-cycle write-through: a write to a source register this edge wins over the stale entry.
  always_comb begin
    rs_fwd = (wb_en && (wb_addr == rs_idx) && (rs_idx != 5'd0)) ? wb_data : rs_rd;
    rt_fwd = (wb_en && (wb_addr == rt_idx) && (rt_idx != 5'd0)) ? wb_data : rt_rd;
    rt_sel = use_imm ? ext_imm(instr[15:0], sext_imm) : rt_fwd;
  end

  // Next-state for the output registers: hold on stall, zero on bubble/illegal.
  always_comb begin
    rs_d       = rs_q;
    rt_d       = rt_q;
    alu_d      = alu_q;
    shamt_d    = shamt_q;
    dest_d     = dest_q;
    ex_valid_d = ex_valid_q;
    illegal_d  = 1'b0;
    cnt_d      = cnt_q;
    if (!stall) begin
      rs_d       = '0;
      rt_d       = '0;
      alu_d      = ALU_NONE;
      shamt_d    = '0;
      dest_d     = '0;
      ex_valid_d = 1'b0;
      if (instr_valid) begin
        if (legal) begin
          rs_d       = rs_fwd;
          rt_d       = rt_sel;
          alu_d      = alu_dec;
          shamt_d    = shamt_dec;
          dest_d     = dest_dec;
          ex_valid_d = 1'b1;
        end else begin
          illegal_d = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  // Output register bank.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs_q       <= '0;
      rt_q       <= '0;
      alu_q      <= ALU_NONE;
      shamt_q    <= '0;
      dest_q     <= '0;
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      alu_q      <= alu_d;
      shamt_q    <= shamt_d;
      dest_q     <= dest_d;
      ex_valid_q <= ex_valid_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rs            = rs_q;
  assign rs_unsigned   = rs_q;
  assign rt            = rt_q;
  assign rt_unsigned   = rt_q;
  assign ALUOp         = alu_q;
  assign shamt         = shamt_q;
  assign dest          = dest_q;
  assign ex_valid      = ex_valid_q;
  assign illegal       = illegal_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage.
module tb_decode_stage;

  logic        clock, reset_n, instr_valid, stall, wb_en;
  logic [31:0] instr, wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] rs, rs_unsigned, rt, rt_unsigned;
  logic [3:0]  ALUOp;
  logic [4:0]  shamt, dest;
  logic        ex_valid, illegal;
  logic [7:0]  illegal_count;

  int tests_run = 0;
  int tests_failed = 0;

  decode_stage dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .stall         (stall),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .rs            (rs),
    .rs_unsigned   (rs_unsigned),
    .rt            (rt),
    .rt_unsigned   (rt_unsigned),
    .ALUOp         (ALUOp),
    .shamt         (shamt),
    .dest          (dest),
    .ex_valid      (ex_valid),
    .illegal       (illegal),
    .illegal_count (illegal_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle outputs away from the edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    instr_valid = v;
    instr = ins;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    drive(1'b0, 32'd0);
    #3;
    tests_run++; if (rs !== 32'd0 || rt !== 32'd0) begin tests_failed++; $display("FAIL reset_operands: rs=%h rt=%h want 0", rs, rt); end
    tests_run++; if (ALUOp !== 4'd0 || ex_valid !== 1'b0 || illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_ctrl: aluop=%h ex_valid=%b illegal=%b want 0", ALUOp, ex_valid, illegal); end
    tests_run++; if (illegal_count !== 8'd0 || dest !== 5'd0) begin tests_failed++; $display("FAIL reset_count: count=%0d dest=%0d want 0", illegal_count, dest); end
    #2 reset_n = 1'b1;
  endtask

  task automatic test_writeback_rtype();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5; drive(1'b0, 32'd0);
    cycle();
    wb_addr = 5'd2; wb_data = 32'hFFFF_FFFD;
    cycle();
    wb_en = 1'b0; drive(1'b1, 32'h0022_1820);
    cycle();
    tests_run++; if (rs !== 32'd5 || rs_unsigned !== 32'd5) begin tests_failed++; $display("FAIL add_rs: got %h/%h want 00000005", rs, rs_unsigned); end
    tests_run++; if (rt !== 32'hFFFF_FFFD || rt_unsigned !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL add_rt: got %h/%h want fffffffd", rt, rt_unsigned); end
    tests_run++; if (ALUOp !== 4'h1 || dest !== 5'd3 || ex_valid !== 1'b1 || illegal !== 1'b0) begin tests_failed++; $display("FAIL add_ctrl: aluop=%h dest=%0d ex_valid=%b illegal=%b want 1/3/1/0", ALUOp, dest, ex_valid, illegal); end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h1234; drive(1'b1, 32'h0080_2823);
    cycle();
    tests_run++; if (rs !== 32'h1234 || rt !== 32'd0) begin tests_failed++; $display("FAIL bypass_ops: rs=%h rt=%h want 00001234/0", rs, rt); end
    tests_run++; if (ALUOp !== 4'hB || dest !== 5'd5) begin tests_failed++; $display("FAIL bypass_ctrl: aluop=%h dest=%0d want b/5", ALUOp, dest); end
    wb_en = 1'b0; drive(1'b1, 32'h0080_4020);
    cycle();
    tests_run++; if (rs !== 32'h1234 || dest !== 5'd8) begin tests_failed++; $display("FAIL bypass_stored: rs=%h dest=%0d want 00001234/8", rs, dest); end
    drive(1'b0, 32'h2006_FFFF);
    cycle();
    tests_run++; if (ex_valid !== 1'b0 || ALUOp !== 4'd0 || dest !== 5'd0 || illegal !== 1'b0 || rt !== 32'd0) begin tests_failed++; $display("FAIL bubble: ex_valid=%b aluop=%h dest=%0d illegal=%b rt=%h want all 0", ex_valid, ALUOp, dest, illegal, rt); end
  endtask

  task automatic test_immediates();
    drive(1'b1, 32'h2006_FFFF);
    cycle();
    tests_run++; if (rt !== 32'hFFFF_FFFF || ALUOp !== 4'h1 || dest !== 5'd6) begin tests_failed++; $display("FAIL addi: rt=%h aluop=%h dest=%0d want ffffffff/1/6", rt, ALUOp, dest); end
    drive(1'b1, 32'h3006_FFFF);
    cycle();
    tests_run++; if (rt !== 32'h0000_FFFF || ALUOp !== 4'h3 || dest !== 5'd6) begin tests_failed++; $display("FAIL andi: rt=%h aluop=%h dest=%0d want 0000ffff/3/6", rt, ALUOp, dest); end
    drive(1'b1, 32'h0001_3903);
    cycle();
    tests_run++; if (ALUOp !== 4'h9 || shamt !== 5'd4 || dest !== 5'd7 || rt !== 32'd5) begin tests_failed++; $display("FAIL sra: aluop=%h shamt=%0d dest=%0d rt=%h want 9/4/7/5", ALUOp, shamt, dest, rt); end
    drive(1'b1, 32'h3429_8000);
    cycle();
    tests_run++; if (rt !== 32'h0000_8000 || rs !== 32'd5 || ALUOp !== 4'h4 || dest !== 5'd9 || shamt !== 5'd0) begin tests_failed++; $display("FAIL ori: rt=%h rs=%h aluop=%h dest=%0d shamt=%0d want 00008000/5/4/9/0", rt, rs, ALUOp, dest, shamt); end
    drive(1'b1, 32'h240A_8000);
    cycle();
    tests_run++; if (rt !== 32'hFFFF_8000 || ALUOp !== 4'hA || dest !== 5'd10) begin tests_failed++; $display("FAIL addiu: rt=%h aluop=%h dest=%0d want ffff8000/a/10", rt, ALUOp, dest); end
    drive(1'b1, 32'h2823_FFFE);
    cycle();
    tests_run++; if (rt !== 32'hFFFF_FFFE || rs !== 32'd5 || ALUOp !== 4'h6 || dest !== 5'd3) begin tests_failed++; $display("FAIL slti: rt=%h rs=%h aluop=%h dest=%0d want fffffffe/5/6/3", rt, rs, ALUOp, dest); end
    drive(1'b1, 32'h0000_0000);
    cycle();
    tests_run++; if (ALUOp !== 4'h7 || dest !== 5'd0 || ex_valid !== 1'b1 || illegal !== 1'b0) begin tests_failed++; $display("FAIL nop_sll: aluop=%h dest=%0d ex_valid=%b illegal=%b want 7/0/1/0", ALUOp, dest, ex_valid, illegal); end
  endtask

  task automatic test_stall();
    logic [31:0] stall_instrs [3];
    stall_instrs[0] = 32'hFC00_0000;
    stall_instrs[1] = 32'h2006_FFFF;
    stall_instrs[2] = 32'h0001_3903;
    drive(1'b1, 32'h0022_1820);
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, stall_instrs[i]);
      wb_en = (i == 1); wb_addr = 5'd1; wb_data = 32'h77;
      cycle();
      tests_run++; if (rs !== 32'd5 || rt !== 32'hFFFF_FFFD || ALUOp !== 4'h1 || dest !== 5'd3 || ex_valid !== 1'b1 || shamt !== 5'd0) begin tests_failed++; $display("FAIL stall_hold[%0d]: rs=%h rt=%h aluop=%h dest=%0d ex_valid=%b shamt=%0d want 5/fffffffd/1/3/1/0", i, rs, rt, ALUOp, dest, ex_valid, shamt); end
      tests_run++; if (illegal !== 1'b0 || illegal_count !== 8'd0) begin tests_failed++; $display("FAIL stall_illegal[%0d]: illegal=%b count=%0d want 0/0", i, illegal, illegal_count); end
    end
    stall = 1'b0; wb_en = 1'b0;
    drive(1'b1, 32'h0022_1820);
    cycle();
    tests_run++; if (rs !== 32'h77 || ex_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_write: rs=%h ex_valid=%b want 00000077/1", rs, ex_valid); end
  endtask

  task automatic test_zero_reg();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD; drive(1'b1, 32'h0000_5820);
    cycle();
    tests_run++; if (rs !== 32'd0 || rt !== 32'd0) begin tests_failed++; $display("FAIL zero_bypass: rs=%h rt=%h want 0/0", rs, rt); end
    wb_en = 1'b0;
    cycle();
    tests_run++; if (rs !== 32'd0 || rt !== 32'd0 || dest !== 5'd11 || ALUOp !== 4'h1) begin tests_failed++; $display("FAIL zero_read: rs=%h rt=%h dest=%0d aluop=%h want 0/0/11/1", rs, rt, dest, ALUOp); end
  endtask

  task automatic test_illegal();
    int exp_cnt;
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 32'hFC00_0000);
      cycle();
      exp_cnt = (k + 1 > 255) ? 255 : k + 1;
      tests_run++; if (illegal !== 1'b1 || ex_valid !== 1'b0 || ALUOp !== 4'd0 || dest !== 5'd0) begin tests_failed++; $display("FAIL illegal_flags[%0d]: illegal=%b ex_valid=%b aluop=%h dest=%0d want 1/0/0/0", k, illegal, ex_valid, ALUOp, dest); end
      tests_run++; if (illegal_count !== exp_cnt[7:0]) begin tests_failed++; $display("FAIL illegal_count[%0d]: got %0d want %0d", k, illegal_count, exp_cnt); end
    end
    drive(1'b1, 32'h0000_0001);
    cycle();
    tests_run++; if (illegal !== 1'b1 || ex_valid !== 1'b0 || illegal_count !== 8'd255) begin tests_failed++; $display("FAIL illegal_funct: illegal=%b ex_valid=%b count=%0d want 1/0/255", illegal, ex_valid, illegal_count); end
    drive(1'b1, 32'h0022_1820);
    cycle();
    tests_run++; if (illegal !== 1'b0 || ex_valid !== 1'b1 || illegal_count !== 8'd255) begin tests_failed++; $display("FAIL illegal_pulse: illegal=%b ex_valid=%b count=%0d want 0/1/255", illegal, ex_valid, illegal_count); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'h0022_1820);
    cycle();
    #2 reset_n = 1'b0;
    stall = 1'b1; wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
    #1;
    tests_run++; if (ex_valid !== 1'b0 || ALUOp !== 4'd0 || rs !== 32'd0 || rt !== 32'd0 || dest !== 5'd0) begin tests_failed++; $display("FAIL midreset_out: ex_valid=%b aluop=%h rs=%h rt=%h dest=%0d want 0", ex_valid, ALUOp, rs, rt, dest); end
    tests_run++; if (illegal_count !== 8'd0 || illegal !== 1'b0) begin tests_failed++; $display("FAIL midreset_count: count=%0d illegal=%b want 0/0", illegal_count, illegal); end
    cycle();
    #1 reset_n = 1'b1;
    stall = 1'b0; wb_en = 1'b0;
    drive(1'b1, 32'h0022_1820);
    cycle();
    tests_run++; if (rs !== 32'd0 || rt !== 32'd0 || ex_valid !== 1'b1 || dest !== 5'd3) begin tests_failed++; $display("FAIL midreset_regs: rs=%h rt=%h ex_valid=%b dest=%0d want 0/0/1/3", rs, rt, ex_valid, dest); end
  endtask

  initial begin
    test_reset();
    test_writeback_rtype();
    test_bypass();
    test_immediates();
    test_stall();
    test_zero_reg();
    test_illegal();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage that sits directly upstream of the ALU. Each rising clock edge it takes one instruction word, decodes it into the 4-bit ALUOp and shamt, and reads the 32×32 register file. It then registers rs/rt operands, both signed and unsigned copies, for the ALU to sample on the following falling edge. It owns the register file, including the write-back port, a same-cycle write-through bypass and illegal-instruction accounting.

## Interface
- No parameters; widths fixed by the MIPS-32 datapath.
- clock  in  1  single clock; stage updates on posedge (ALU samples on negedge)
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instr carries a real instruction this cycle
- instr  in  32  MIPS instruction word
- stall  in  1  hold all stage outputs
- wb_en  in  1  register write-back enable
- wb_addr  in  5  write-back register index
- wb_data  in  32  write-back data
- rs, rs_unsigned  out  32  operand A (identical bits, signed/unsigned views)
- rt, rt_unsigned  out  32  operand B: register rt or extended immediate
- ALUOp  out  4  ALU function code
- shamt  out  5  instr[10:6] for R-type shifts, else 0
- dest  out  5  destination register (rd for R-type, rt for I-type, 0 when none)
- ex_valid  out  1  outputs hold a valid decoded instruction
- illegal  out  1  one-cycle pulse: the last accepted instruction was undecodable
- illegal_count  out  8  saturating count of illegal instructions

## Operation
- ALUOp codes: 0000 none, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 NOR, 0110 SLT, 0111 SLL, 1000 SRL, 1001 SRA, 1010 ADDU, 1011 SUBU.
- R-type (opcode 0x00) funct map: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL, 0x03 SRA.
- I-type: 0x08 addi→ADD, 0x09 addiu→ADDU, 0x0C andi→AND, 0x0D ori→OR, 0x0A slti→SLT.
  - rt output is the immediate: sign-extended for addi/addiu/slti, zero-extended for andi/ori.
  - dest = instr[20:16].
- Any other opcode/funct is illegal:
  - ALUOp=0000, ex_valid=0, dest=0.
  - illegal pulses 1.
  - illegal_count increments, saturating at 255.
- All-zero instruction (sll $0,$0,0) is legal: ALUOp=0111, dest=0.
- Register file:
  - 32 entries; $0 reads 0 always; writes to $0 ignored.
  - Write on posedge when wb_en=1.
  - Read bypass: if wb_en=1 and wb_addr equals a nonzero source index in the same cycle, the stage latches wb_data, not the stale entry.

## Timing
- Reset (reset_n=0, asynchronous): all outputs 0, ALUOp=0000, ex_valid=0, illegal=0, illegal_count=0, all registers 0. Reset overrides stall and wb_en.
- Latency 1: instruction presented before posedge N appears on outputs after posedge N. ALU consumes it at negedge N.
- stall=1:
  - All outputs hold; the instruction on instr is not consumed.
  - illegal forced 0; illegal_count holds.
  - Register-file writes still occur. Held operand outputs are not refreshed by them.
- stall=0, instr_valid=0: bubble. ex_valid=0, ALUOp=0000, dest=0, illegal=0; other outputs don't-care (drive 0).
- Back-to-back valid instructions are accepted every cycle with no gap.

## Structure
- Shared package alu_defs_pkg:
  - ALUOp constants (also used by the ALU).
  - Opcode and funct constants.
- Sub-module mips_regfile:
  - 2 async read ports, 1 sync write port, async reset.
  - Bypass logic lives in decode_stage.

## Test plan
- Reset mid-stream: assert reset_n=0 while ex_valid=1 → outputs immediately 0, ALUOp=0000, illegal_count=0; reading any register afterwards returns 0.
- Write-back then R-type: write $1=5, $2=0xFFFFFFFD; then add $3,$1,$2 (0x00221820) → rs=5, rt=0xFFFFFFFD, ALUOp=0001, dest=3, ex_valid=1 one cycle later.
- Bypass: in the same cycle, wb_en=1, wb_addr=4, wb_data=0x1234, and subu $5,$4,$0 → rs=0x1234, rt=0, ALUOp=1011.
- Immediates:
  - addi $6,$0,-1 → rt=0xFFFFFFFF, ALUOp=0001, dest=6.
  - andi $6,$0,0xFFFF → rt=0x0000FFFF, ALUOp=0011.
  - sra $7,$1,4 → ALUOp=1001, shamt=4.
- Stall and $0:
  - Hold stall=1 for 3 cycles while instr changes → outputs unchanged.
  - Write $0=0xDEAD, then read $0 → 0.
- Illegal: 300 consecutive instructions with opcode 0x3F → each has illegal=1, ex_valid=0, ALUOp=0000; illegal_count ends at 255.
